// File: rtl/apb_reg_native_mst_if.sv
// apb_reg_native_mst_if: APB3 slave side and native request side of the register-tree initiator
interface apb_reg_native_mst_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;
    logic                      req_vld;
    logic                      ack_vld;
    logic                      wr_en;
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      soft_rst_o;
    logic                      busy;

    modport master (
        input  psel, penable, pwrite, paddr, pwdata, ack_vld, rd_data,
        output pready, prdata, pslverr, req_vld, wr_en, rd_en, addr, wr_data, soft_rst_o, busy
    );

    modport slave (
        output psel, penable, pwrite, paddr, pwdata, ack_vld, rd_data,
        input  pready, prdata, pslverr, req_vld, wr_en, rd_en, addr, wr_data, soft_rst_o, busy
    );
endinterface

// File: rtl/apb_reg_native_mst.sv
// apb_reg_native_mst: APB3 to native register request bridge with ack timeout and downstream soft reset
module apb_reg_native_mst #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT        = 256,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    apb_reg_native_mst_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.pready     <= 1'b0;
            bus.prdata     <= '0;
            bus.pslverr    <= 1'b0;
            bus.req_vld    <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.addr       <= '0;
            bus.wr_data    <= '0;
            bus.soft_rst_o <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.req_vld    <= 1'b0;
            bus.soft_rst_o <= 1'b0;
            case (state)
                IDLE: if (bus.psel && !bus.penable) begin
                    bus.busy <= 1'b1;
                    if (bus.paddr[1:0] != 2'b00) begin
                        state       <= RESP;
                        bus.pready  <= 1'b1;
                        bus.pslverr <= 1'b1;
                        bus.prdata  <= '0;
                    end else begin
                        state       <= WAIT;
                        cnt         <= '0;
                        bus.req_vld <= 1'b1;
                        bus.wr_en   <= bus.pwrite;
                        bus.rd_en   <= !bus.pwrite;
                        bus.addr    <= ADDR_WIDTH'(bus.paddr);
                        bus.wr_data <= bus.pwrite ? bus.pwdata : '0;
                    end
                end
                // ack takes priority over an expiring counter in the same cycle
                WAIT: if (bus.ack_vld) begin
                    state       <= RESP;
                    bus.pready  <= 1'b1;
                    bus.pslverr <= 1'b0;
                    bus.prdata  <= bus.rd_en ? bus.rd_data : '0;
                    bus.wr_en   <= 1'b0;
                    bus.rd_en   <= 1'b0;
                end else if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                    state          <= RESP;
                    bus.pready     <= 1'b1;
                    bus.pslverr    <= 1'b1;
                    bus.prdata     <= '0;
                    bus.soft_rst_o <= 1'b1;
                    bus.wr_en      <= 1'b0;
                    bus.rd_en      <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    bus.pready  <= 1'b0;
                    bus.pslverr <= 1'b0;
                    bus.prdata  <= '0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_reg_native_mst.sv
// tb_apb_reg_native_mst: directed and random APB transfers against a transfer-level outcome model
module tb_apb_reg_native_mst;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    apb_reg_native_mst_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .APB_ADDR_WIDTH(32)) bus ();

    apb_reg_native_mst #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] all_out();
        return {bus.pready, bus.prdata, bus.pslverr, bus.req_vld, bus.wr_en, bus.rd_en,
                bus.addr, bus.wr_data, bus.soft_rst_o, bus.busy};
    endfunction

    // One APB transfer; dly = WAIT cycles after the req_vld cycle before ack is driven
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] rd);
        logic        mis = a[1:0] != 2'b00;
        logic        tmo = !mis && dly >= TO;
        logic        err = mis || tmo;
        int          exp_waits = mis ? 0 : (tmo ? TO : dly + 1);
        logic [31:0] exp_rd = (!err && !w) ? rd : 32'h0;
        int          k = 0;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
        @(negedge clk);
        bus.penable = 1'b1;
        while (!bus.pready && k < 40) begin
            check("wait", {bus.pready, bus.req_vld, bus.wr_en, bus.rd_en, bus.busy, bus.soft_rst_o,
                           bus.addr, bus.wr_data},
                  {1'b0, k == 0, w, !w, 1'b1, 1'b0, {32'h0, a}, w ? d : 32'h0});
            bus.ack_vld = (k == dly);
            bus.rd_data = (k == dly) ? rd : $urandom;
            @(negedge clk);
            k++;
        end
        bus.ack_vld = 1'b0;
        check("waits", 256'(k), 256'(exp_waits));
        check("resp", {bus.pready, bus.pslverr, bus.req_vld, bus.wr_en, bus.rd_en, bus.busy,
                       bus.soft_rst_o, bus.prdata},
              {1'b1, err, 1'b0, 1'b0, 1'b0, 1'b1, tmo, exp_rd});
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        check("idle", {bus.pready, bus.pslverr, bus.prdata, bus.busy, bus.soft_rst_o, bus.req_vld},
              '0);
        if (tmo) begin
            bus.ack_vld = 1'b1;
            bus.rd_data = $urandom | 32'h1;
            @(negedge clk);
            bus.ack_vld = 1'b0;
            check("late_ack", {bus.pready, bus.prdata, bus.busy, bus.soft_rst_o}, '0);
        end
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
        bus.pwdata = '0; bus.ack_vld = 1'b0; bus.rd_data = '0;
        #3 check("reset", all_out(), '0);
        @(negedge clk); @(negedge clk);
        check("reset_hold", all_out(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b1, 32'h4, 32'hA5A5_0001, 0, 32'h0);
        xfer(1'b0, 32'h10, 32'h0, 3, 32'h1234_5678);
        xfer(1'b0, 32'h8, 32'h0, 100, 32'hDEAD_BEEF);
        xfer(1'b0, 32'hC, 32'h0, TO - 1, 32'hCAFE_F00D);
        xfer(1'b1, 32'h6, 32'h5555_AAAA, 0, 32'h0);
        // abort a read mid-WAIT with asynchronous reset
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h20;
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk); @(negedge clk);
        check("pre_rst_busy", {bus.busy, bus.rd_en}, {1'b1, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("async_rst", all_out(), '0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        check("rst_no_soft", all_out(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b1, 32'h0, 32'h0BAD_F00D, 2, 32'h0);
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a = $urandom & 32'hFFFF_FFFC;
            int          dly = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 4)
                                                           : $urandom_range(0, TO - 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            xfer(1'($urandom_range(0, 1)), a, $urandom, dly, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_reg_native_mst.md
Name: apb_reg_native_mst

Overview:
- Initiator end of the native register protocol: converts APB3 slave transfers from the CPU bus into single-outstanding native requests (req_vld / wr_en / rd_en / addr / wr_data) toward a generated regslv or dispatcher.
- Collects ack_vld and rd_data and completes the APB access.
- Sits at the top of the register tree and owns timeout recovery: a hung transfer is aborted and a soft reset is pulsed downstream.

Parameters:
- ADDR_WIDTH, 64, native address width (zero-extended from paddr).
- DATA_WIDTH, 32, native and APB data width.
- APB_ADDR_WIDTH, 32, paddr width; must be <= ADDR_WIDTH.
- TIMEOUT, 256, cycles to wait for ack_vld before abort; must be >= 2.
- CNT_WIDTH, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  single clock for both sides.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  APB_ADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- pready  out  1  APB completion.
- prdata  out  DATA_WIDTH  APB read data.
- pslverr  out  1  APB error.
- req_vld  out  1  native request strobe.
- ack_vld  in  1  native completion strobe.
- wr_en  out  1  native write qualifier.
- rd_en  out  1  native read qualifier.
- addr  out  ADDR_WIDTH  native address.
- wr_data  out  DATA_WIDTH  native write data.
- rd_data  in  DATA_WIDTH  native read data, valid only with ack_vld.
- soft_rst_o  out  1  synchronous soft-reset pulse to the downstream FSM.
- busy  out  1  transfer in flight (state != IDLE).

Behaviour:
- Reset: every output is 0, state = IDLE, counter = 0. All outputs are registered.
- States are IDLE, WAIT and RESP.
- IDLE:
  - A sample with psel=1, penable=0 (APB setup) launches a transfer.
  - If paddr[1:0] != 0: go to RESP with pslverr=1 and prdata=0; no native request is issued.
  - Otherwise, next cycle:
    - req_vld=1 for exactly one cycle.
    - wr_en=pwrite and rd_en=~pwrite.
    - addr = paddr zero-extended to ADDR_WIDTH.
    - wr_data = pwdata on write, 0 on read.
    - counter = 0; go to WAIT.
- WAIT:
  - addr, wr_en, rd_en and wr_data are held stable until the transfer ends.
  - ack_vld is sampled every cycle, including the req_vld cycle, so a same-cycle ack is legal.
  - On ack_vld:
    - prdata = rd_data on read, 0 on write; pslverr = 0.
    - wr_en and rd_en clear next cycle; go to RESP.
  - Without ack, the counter increments.
  - When the counter reaches TIMEOUT-1 without ack:
    - Go to RESP with pslverr=1 and prdata=0.
    - soft_rst_o=1 for one cycle, coincident with RESP.
    - wr_en and rd_en clear.
  - ack_vld and timeout in the same cycle: ack wins, no error, no soft_rst_o.
- RESP:
  - pready=1 for exactly one cycle, then IDLE; pready, pslverr and prdata return to 0 in that IDLE cycle.
  - psel/penable are not re-checked (APB guarantees the access phase).
- Unsolicited ack_vld in IDLE or RESP (e.g. a late ack after a timeout) is ignored; it causes no state change and no prdata update.
- psel held across back-to-back transfers: a new setup is only recognised in IDLE, so the minimum APB transfer is 3 cycles (setup, req/ack, RESP).
- Asynchronous reset mid-transfer: immediate return to reset values. No soft_rst_o is generated by reset itself.
- busy = 1 in WAIT and RESP.

Test Plan:
- Write, ack same cycle as req_vld: paddr=0x4, pwdata=0xA5A5_0001 -> req_vld 1 cycle with wr_en=1, addr=64'h4, wr_data=0xA5A5_0001; pready 1 cycle later with pslverr=0.
- Read, ack 3 cycles after req_vld with rd_data=0x1234_5678 -> addr/rd_en stable for 4 cycles; prdata=0x1234_5678 with pready; prdata=0 the following cycle.
- Timeout, TIMEOUT=16, no ack -> pready with pslverr=1 and prdata=0 after 16 WAIT cycles; soft_rst_o pulses once in the same cycle; a late ack 2 cycles later is ignored and busy=0.
- Boundary, TIMEOUT=16: ack on the 16th WAIT cycle -> pslverr=0, soft_rst_o stays 0, read data captured.
- Misaligned paddr=0x6 -> req_vld never asserted; pready with pslverr=1 on the cycle after setup.
- Reset asserted in WAIT during a read -> all outputs 0 asynchronously; after release, a new write at 0x0 completes normally.
